cdb_arbiter: RTL

- Round-robin scheduler that shares the single CDB data broadcast lane between all functional units (ALU, store and load reservation stations).
- Each FU holds a completed result with `req` high. The arbiter picks one FU per cycle, registers its data, address and RB index onto the CDB outputs, and pulses `grant` back to that FU.
- Sits between the FU result buses and the CDB data controller / reorder buffer. Honours back-pressure from the reorder buffer and a flush on mispredict.

---
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB broadcast lane between all functional units.
// One FU result is granted per cycle and registered onto the cdb_* outputs.
module cdb_arbiter #(
    parameter int FU_NUM    = 8,
    parameter int FU_INDEX  = 3,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FU_NUM-1:0]             req,
    input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
    input  logic [FU_NUM*WORD_SIZE-1:0]   addr_bus,
    input  logic [FU_NUM*RB_INDEX-1:0]    rb_index_bus,
    input  logic                          cdb_ready,
    input  logic                          flush,
    output logic [FU_NUM-1:0]             grant,
    output logic                          cdb_valid,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [WORD_SIZE-1:0]          cdb_addr,
    output logic [RB_INDEX-1:0]           cdb_rb_index,
    output logic [FU_INDEX-1:0]           cdb_fu
);

    localparam logic [FU_INDEX:0] FU_NUM_W = (FU_INDEX+1)'(FU_NUM);

    logic [FU_INDEX-1:0]    ptr;
    logic                   load;
    logic                   any_req;
    logic                   take;
    logic [2*FU_NUM-2:0]    req_dbl;
    logic [FU_NUM-1:0]      req_rot;
    logic [FU_INDEX-1:0]    offset;
    logic [FU_INDEX:0]      sel_sum;
    logic [FU_INDEX-1:0]    sel;
    logic [FU_INDEX:0]      next_sum;
    logic [FU_INDEX-1:0]    ptr_next;
    logic [WORD_SIZE-1:0]   sel_data;
    logic [WORD_SIZE-1:0]   sel_addr;
    logic [RB_INDEX-1:0]    sel_rb_index;

    assign load    = ~flush & (~cdb_valid | cdb_ready);
    assign any_req = |req;
    assign take    = reset & load & any_req;

    // Rotating req so that bit 0 is the FU at ptr turns the wrapping search into a plain lowest-bit find.
    assign req_dbl = {req[FU_NUM-2:0], req};
    assign req_rot = req_dbl[ptr +: FU_NUM];

    always_comb begin
        offset = '0;
        for (int k = FU_NUM - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = FU_INDEX'(k);
            end
        end
    end

    always_comb begin
        sel_sum = {1'b0, ptr} + {1'b0, offset};
        if (sel_sum >= FU_NUM_W) begin
            sel_sum = sel_sum - FU_NUM_W;
        end
        sel = sel_sum[FU_INDEX-1:0];
    end

    always_comb begin
        next_sum = {1'b0, sel} + (FU_INDEX+1)'(1);
        if (next_sum >= FU_NUM_W) begin
            next_sum = '0;
        end
        ptr_next = next_sum[FU_INDEX-1:0];
    end

    always_comb begin
        sel_data     = '0;
        sel_addr     = '0;
        sel_rb_index = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (sel == FU_INDEX'(i)) begin
                sel_data     = data_bus[i*WORD_SIZE +: WORD_SIZE];
                sel_addr     = addr_bus[i*WORD_SIZE +: WORD_SIZE];
                sel_rb_index = rb_index_bus[i*RB_INDEX +: RB_INDEX];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (take) begin
            grant = FU_NUM'(1) << sel;
        end
    end

    // Flush and an empty load both drop valid; the payload is left untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid    <= 1'b0;
            cdb_data     <= '0;
            cdb_addr     <= '0;
            cdb_rb_index <= '0;
            cdb_fu       <= '0;
            ptr          <= '0;
        end else if (take) begin
            cdb_valid    <= 1'b1;
            cdb_data     <= sel_data;
            cdb_addr     <= sel_addr;
            cdb_rb_index <= sel_rb_index;
            cdb_fu       <= sel;
            ptr          <= ptr_next;
        end else if (load || flush) begin
            cdb_valid    <= 1'b0;
        end
    end

    a_grant_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
    a_grant_load   : assert property (@(posedge clk) disable iff (!reset) (grant != '0) |-> load);
    a_no_x_valid   : assert property (@(posedge clk) disable iff (!reset)
        cdb_valid |-> !$isunknown({cdb_data, cdb_addr, cdb_rb_index, cdb_fu}));

endmodule
